riscv_muldiv_unit: RTL and testbench

Parametrised RV32M/RV64M multiply/divide execute unit for the pipelined core. It is instantiated beside the ALU in the execute stage. It accepts one operation at a time through a start/busy/done handshake, and the hazard logic stalls the pipeline while busy. It generalises the single-cycle ALU path: operand width is XLEN, the multiplier style is selectable, the divider is iterative, and the block adds flush/abort behaviour.

---
 rtl/riscv_muldiv_pkg.sv | 39 +++
 rtl/riscv_div_iter.sv | 57 +++++
 rtl/riscv_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the M-extension execute unit: funct3 codes, FSM states,
// latched-op record and the per-op operand signedness decode.
package riscv_muldiv_pkg;

   localparam logic [2:0] MULDIV_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_REM    = 3'b110;
   localparam logic [2:0] MULDIV_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_t;

   typedef struct packed {
      logic [2:0] funct3;
      logic       neg_main;   // negate product / quotient in the fixup cycle
      logic       neg_rem;    // remainder follows the dividend sign
   } muldiv_op_t;

   // {rs1_signed, rs2_signed}; MUL keeps the low half so signedness is irrelevant
   function automatic logic [1:0] operand_signs(input logic [2:0] funct3);
      logic [1:0] s;
      case (funct3)
         MULDIV_MULH, MULDIV_DIV, MULDIV_REM: s = 2'b11;
         MULDIV_MULHSU:                       s = 2'b10;
         default:                             s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/riscv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step;
// XLEN steps after load, last is high during the final step.
module riscv_div_iter
   import riscv_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            step,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            last
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN:0]   part, diff;

   // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
   assign part = {rem_q, quo_q[XLEN-1]};
   assign diff = part - {1'b0, dvs_q};

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign last      = (cnt_q == LAST_CNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
      end else if (step) begin
         if (diff[XLEN]) begin
            rem_q <= part[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end else begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end
         if (!last) cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// RV32M/RV64M multiply/divide unit, start/busy/done handshake; latency 1 (fast paths),
// XLEN+1 (iterative MUL) or XLEN+2 (DIV/REM); start ignored while busy, flush aborts.
module riscv_muldiv_unit
   import riscv_muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

   muldiv_state_t     state;
   muldiv_op_t        op_q;
   logic [XLEN-1:0]   mcand_q;
   logic [2*XLEN-1:0] prod_q;
   logic [CW-1:0]     mul_cnt;

   logic [1:0]        sgn;
   logic              a_neg, b_neg, is_div, div_zero, ovf, accept, div_load, div_last;
   logic [XLEN-1:0]   mag_a, mag_b, div_quo, div_rem, quo_signed, rem_signed, fix_val;
   logic [2*XLEN-1:0] fast_prod, fast_signed, prod_signed;

   // shift-add step: conditionally add multiplicand to the high half, then shift right
   function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0]   m);
      logic [XLEN:0] sum;
      sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
      return {sum, p[XLEN-1:1]};
   endfunction

   function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] p, input logic [2:0] f);
      return (f == MULDIV_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   endfunction

   assign sgn      = operand_signs(funct3);
   assign a_neg    = sgn[1] & rs1[XLEN-1];
   assign b_neg    = sgn[0] & rs2[XLEN-1];
   assign mag_a    = a_neg ? -rs1 : rs1;
   assign mag_b    = b_neg ? -rs2 : rs2;
   assign is_div   = funct3[2];
   assign div_zero = (rs2 == '0);
   assign ovf      = sgn[1] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
   assign accept   = start & ~busy & ~flush;
   assign div_load = accept & is_div & ~div_zero & ~ovf;

   assign fast_prod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
   assign fast_signed = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
   assign prod_signed = op_q.neg_main ? -prod_q : prod_q;
   assign quo_signed  = op_q.neg_main ? -div_quo : div_quo;
   assign rem_signed  = op_q.neg_rem ? -div_rem : div_rem;
   assign fix_val     = op_q.funct3[2] ? (op_q.funct3[1] ? rem_signed : quo_signed)
                                       : pick(prod_signed, op_q.funct3);

   riscv_div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .step      ((state == ST_DIV) & ~flush),
      .quotient  (div_quo),
      .remainder (div_rem),
      .last      (div_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         op_q    <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         mul_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_MUL: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  prod_q <= mul_step(prod_q, mcand_q);
                  if (mul_cnt == LAST_CNT) state   <= ST_FIX;
                  else                     mul_cnt <= mul_cnt + CW'(1);
               end
            end
            ST_DIV: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (div_last) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               state <= flush ? ST_IDLE : ST_DONE;
               busy  <= 1'b0;
               if (!flush) begin
                  result <= fix_val;
                  done   <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               if (accept) begin
                  op_q <= '{funct3: funct3, neg_main: a_neg ^ b_neg, neg_rem: a_neg};
                  if (is_div && (div_zero || ovf)) begin
                     if (div_zero) result <= funct3[1] ? rs1 : '1;
                     else          result <= funct3[1] ? '0 : rs1;
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else if (is_div) begin
                     state <= ST_DIV;
                     busy  <= 1'b1;
                  end else if (FAST_MUL) begin
                     result <= pick(fast_signed, funct3);
                     state  <= ST_DONE;
                     done   <= 1'b1;
                  end else begin
                     // bit 0 of the multiplier is consumed on the accepting edge
                     mcand_q <= mag_a;
                     prod_q  <= mul_step({{XLEN{1'b0}}, mag_b}, mag_a);
                     mul_cnt <= CW'(1);
                     state   <= ST_MUL;
                     busy    <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: three instances (32-bit fast, 32-bit iterative, 64-bit iterative)
// driven with directed and random ops, checked against a wide-integer arithmetic model.
module tb_riscv_muldiv_unit;

   logic        clk, reset;
   logic        start_v [3];
   logic        flush_v [3];
   logic [2:0]  f_v     [3];
   logic [31:0] a32     [2];
   logic [31:0] b32     [2];
   logic [63:0] a64, b64;
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [31:0] r0, r1;
   logic [63:0] r2;
   logic [63:0] res_v   [3];
   logic [63:0] last_res[3];
   int          total, bad;

   assign res_v[0] = {32'd0, r0};
   assign res_v[1] = {32'd0, r1};
   assign res_v[2] = r2;

   riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast32 (
      .clk(clk), .reset(reset), .start(start_v[0]), .funct3(f_v[0]), .rs1(a32[0]), .rs2(b32[0]),
      .flush(flush_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(r0));
   riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_iter32 (
      .clk(clk), .reset(reset), .start(start_v[1]), .funct3(f_v[1]), .rs1(a32[1]), .rs2(b32[1]),
      .flush(flush_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(r1));
   riscv_muldiv_unit #(.XLEN(64), .FAST_MUL(1'b0)) u_iter64 (
      .clk(clk), .reset(reset), .start(start_v[2]), .funct3(f_v[2]), .rs1(a64), .rs2(b64),
      .flush(flush_v[2]), .busy(busy_v[2]), .done(done_v[2]), .result(r2));

   always #5 clk = ~clk;

   function automatic int xlen_of(input int u);
      return (u == 2) ? 64 : 32;
   endfunction

   function automatic logic [63:0] mask(input int xl);
      return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl) - 64'd1);
   endfunction

   // Reference: sign/zero-extend into 128 bits and use plain * / % on wide integers.
   function automatic logic [63:0] ref_op(input int xl, input logic [2:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [127:0]        m128, ea, eb, p;
      logic signed [127:0] q;
      logic                sa, sb;
      logic [63:0]         m;
      m    = mask(xl);
      m128 = {64'd0, m};
      sa   = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
      sb   = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
      ea   = (sa && a[xl-1]) ? ({64'd0, a} | ~m128) : {64'd0, a};
      eb   = (sb && b[xl-1]) ? ({64'd0, b} | ~m128) : {64'd0, b};
      case (f)
         3'd0: begin p = ea * eb; return p[63:0] & m; end
         3'd1, 3'd2, 3'd3: begin p = (ea * eb) >> xl; return p[63:0] & m; end
         3'd4, 3'd5: begin
            if (b == 64'd0) return m;
            q = $signed(ea) / $signed(eb);
            return q[63:0] & m;
         end
         default: begin
            if (b == 64'd0) return a;
            q = $signed(ea) % $signed(eb);
            return q[63:0] & m;
         end
      endcase
   endfunction

   function automatic int ref_lat(input int u, input logic [2:0] f,
                                  input logic [63:0] a, input logic [63:0] b);
      int xl;
      xl = xlen_of(u);
      if (!f[2]) return (u == 0) ? 1 : xl + 1;
      if (b == 64'd0) return 1;
      if (!f[0] && a == (64'd1 << (xl - 1)) && b == mask(xl)) return 1;
      return xl + 2;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int u, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      f_v[u] = f;
      if (u == 2) begin a64 = a; b64 = b; end
      else begin a32[u] = a[31:0]; b32[u] = b[31:0]; end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in the current cycle, follow it to done; a second start is poked at cycle 'poke'.
   task automatic run_op(input int u, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input int poke);
      logic [63:0] m, exp;
      int          lat, k;
      logic        busy_ok, got;
      m   = mask(xlen_of(u));
      exp = ref_op(xlen_of(u), f, a & m, b & m);
      lat = ref_lat(u, f, a & m, b & m);
      drive(u, f, a & m, b & m);
      start_v[u] = 1'b1;
      tick();
      start_v[u] = 1'b0;
      k = 1; busy_ok = 1'b1; got = 1'b0;
      while (k <= 200 && !got) begin
         if (done_v[u]) begin
            got = 1'b1;
            if (busy_v[u] !== 1'b0) busy_ok = 1'b0;
         end else begin
            if (busy_v[u] !== 1'b1) busy_ok = 1'b0;
            if (k == poke) begin
               start_v[u] = 1'b1;
               drive(u, f ^ 3'b001, ~a & m, 64'd3);
            end
            tick();
            start_v[u] = 1'b0;
            k++;
         end
      end
      check($sformatf("u%0d f%0d latency", u, f), 64'(k), 64'(lat));
      check($sformatf("u%0d f%0d result", u, f), res_v[u], exp);
      check($sformatf("u%0d f%0d busy_profile", u, f), {63'd0, busy_ok}, 64'd1);
      last_res[u] = exp;
   endtask

   // Start an op, flush it in cycle 'at', confirm it is dropped silently.
   task automatic flush_test(input int u, input logic [2:0] f, input logic [63:0] a,
                             input logic [63:0] b, input int at);
      logic seen_done;
      seen_done = 1'b0;
      drive(u, f, a & mask(xlen_of(u)), b & mask(xlen_of(u)));
      start_v[u] = 1'b1;
      tick();
      start_v[u] = 1'b0;
      for (int k = 1; k < at; k++) begin
         if (done_v[u]) seen_done = 1'b1;
         tick();
      end
      check($sformatf("u%0d flush_pre_busy", u), {63'd0, busy_v[u]}, 64'd1);
      flush_v[u] = 1'b1;
      tick();
      flush_v[u] = 1'b0;
      if (done_v[u]) seen_done = 1'b1;
      check($sformatf("u%0d flush_busy", u), {63'd0, busy_v[u]}, 64'd0);
      check($sformatf("u%0d flush_no_done", u), {63'd0, seen_done}, 64'd0);
      check($sformatf("u%0d flush_result_held", u), res_v[u], last_res[u]);
   endtask

   task automatic random_ops(input int u, input int n);
      logic [2:0]  f;
      logic [63:0] a, b;
      int          xl;
      xl = xlen_of(u);
      for (int i = 0; i < n; i++) begin
         f = 3'($urandom_range(0, 7));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: b = 64'd0;
            1: begin a = 64'd1 << (xl - 1); b = 64'hFFFF_FFFF_FFFF_FFFF; end
            2: b = 64'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(u, f, a, b, 0);
      end
   endtask

   initial begin
      clk = 1'b0; reset = 1'b0; total = 0; bad = 0;
      a64 = '0; b64 = '0;
      for (int u = 0; u < 3; u++) begin
         start_v[u] = 1'b0; flush_v[u] = 1'b0; f_v[u] = 3'd0; last_res[u] = '0;
      end
      for (int u = 0; u < 2; u++) begin a32[u] = '0; b32[u] = '0; end
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         check($sformatf("u%0d reset_busy", u), {63'd0, busy_v[u]}, 64'd0);
         check($sformatf("u%0d reset_done", u), {63'd0, done_v[u]}, 64'd0);
         check($sformatf("u%0d reset_result", u), res_v[u], 64'd0);
      end
      reset = 1'b1;
      tick();

      for (int u = 0; u < 2; u++) begin
         run_op(u, 3'd0, 64'd7, 64'hFFFF_FFFD, 0);
         run_op(u, 3'd1, 64'h8000_0000, 64'h8000_0000, 0);
         run_op(u, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
         run_op(u, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
      end

      run_op(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 0);
      run_op(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 0);
      run_op(0, 3'd5, 64'd100, 64'd7, 5);
      run_op(0, 3'd7, 64'd100, 64'd7, 0);
      run_op(0, 3'd5, 64'd100, 64'd0, 0);
      run_op(0, 3'd7, 64'd100, 64'd0, 0);
      run_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 0);
      run_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 0);

      flush_test(0, 3'd5, 64'd1000, 64'd7, 10);
      tick();
      run_op(0, 3'd0, 64'd3, 64'd4, 0);
      flush_test(1, 3'd1, 64'h1234_5678, 64'h9ABC_DEF0, 8);
      tick();

      // flush and start together in the done cycle: the start must be dropped
      run_op(0, 3'd0, 64'd9, 64'd9, 0);
      drive(0, 3'd0, 64'd5, 64'd5);
      start_v[0] = 1'b1; flush_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0; flush_v[0] = 1'b0;
      check("flush_start_busy", {63'd0, busy_v[0]}, 64'd0);
      check("flush_start_done", {63'd0, done_v[0]}, 64'd0);
      check("flush_start_result", res_v[0], last_res[0]);

      random_ops(0, 40);
      random_ops(1, 12);

      // asynchronous reset in the middle of a divide
      drive(0, 3'd4, 64'hFFFF_FFF9, 64'd2);
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (4) tick();
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_busy", {63'd0, busy_v[0]}, 64'd0);
      check("async_reset_done", {63'd0, done_v[0]}, 64'd0);
      check("async_reset_result", res_v[0], 64'd0);
      for (int u = 0; u < 3; u++) last_res[u] = '0;
      tick();
      reset = 1'b1;
      tick();
      check("post_reset_no_done", {63'd0, done_v[0]}, 64'd0);

      run_op(2, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
      random_ops(2, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
